// File: rtl/board_pkg.sv
// Shared board geometry: perimeter size, sprite size, step directions and mover states.
package board_pkg;

    localparam int BOARD_TILES = 28;
    localparam int SPRITE_PX   = 16;

    typedef enum logic [1:0] {RIGHT, DOWN, LEFT, UP} dir_t;

    typedef enum logic [1:0] {IDLE, MOVE, DONE} mover_state_t;

    // Direction of travel when leaving tile idx on the clockwise perimeter.
    function automatic dir_t tile_dir(input logic [4:0] idx);
        if (idx <= 5'd6)       return RIGHT;
        else if (idx <= 5'd13) return DOWN;
        else if (idx <= 5'd20) return LEFT;
        else                   return UP;
    endfunction

endpackage

// File: rtl/player_mover_if.sv
// Move request handshake plus position/status outputs between game logic and the mover.
interface player_mover_if;
    logic       frame_tick;
    logic       move_valid;
    logic [3:0] move_steps;
    logic       move_ready;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [4:0] tile_idx;
    logic       busy;
    logic       done;

    modport master (
        output frame_tick, move_valid, move_steps,
        input  move_ready, player_x, player_y, tile_idx, busy, done
    );

    modport slave (
        input  frame_tick, move_valid, move_steps,
        output move_ready, player_x, player_y, tile_idx, busy, done
    );
endinterface

// File: rtl/board_tile_lut.sv
// Perimeter tile index (0..27, clockwise from top-left) to grid {col, row} on the 8x8 board.
module board_tile_lut (
    input  logic [4:0] tile_idx_i,
    output logic [2:0] col_o,
    output logic [2:0] row_o
);
    always_comb begin
        col_o = '0;
        row_o = '0;
        if (tile_idx_i <= 5'd7) begin
            col_o = tile_idx_i[2:0];
        end else if (tile_idx_i <= 5'd13) begin
            col_o = 3'd7;
            row_o = 3'(tile_idx_i - 5'd7);
        end else if (tile_idx_i <= 5'd21) begin
            col_o = 3'(5'd21 - tile_idx_i);
            row_o = 3'd7;
        end else begin
            row_o = 3'(5'd28 - tile_idx_i);
        end
    end
endmodule

// File: rtl/player_mover.sv
// Walks the player token tile-by-tile around the board perimeter, PIX_PER_FRAME pixels per frame.
// Optional PLAYER_HOP_EN adds a parabolic vertical hop during each tile step.
module player_mover
    import board_pkg::*;
#(
    parameter int BOARD_X0      = 192,
    parameter int BOARD_Y0      = 112,
    parameter int TILE_PX       = 32,
    parameter int PIX_PER_FRAME = 2
) (
    input  logic           clk,
    input  logic           reset,
    player_mover_if.slave  mv
);
    localparam int              SH      = $clog2(TILE_PX);
    localparam int              SUBW    = SH + 1;
    localparam logic [SUBW-1:0] SUB_END = SUBW'(TILE_PX);
    localparam logic [SUBW-1:0] STEP    = SUBW'(PIX_PER_FRAME);
    localparam logic [9:0]      OFS     = 10'((TILE_PX - SPRITE_PX) / 2);
    localparam logic [9:0]      X0      = 10'(BOARD_X0);
    localparam logic [9:0]      Y0      = 10'(BOARD_Y0);

    mover_state_t    state_q, state_d;
    logic [3:0]      steps_q, steps_d;
    logic [SUBW-1:0] sub_q, sub_d;
    logic [4:0]      tile_q, tile_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic [2:0]      col, row;
    logic [9:0]      base_x, base_y, sub10, lift;

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        sub_d   = sub_q;
        tile_d  = tile_q;
        unique case (state_q)
            IDLE: begin
                if (mv.move_valid) begin
                    steps_d = mv.move_steps;
                    sub_d   = '0;
                    state_d = (mv.move_steps == 4'd0) ? DONE : MOVE;
                end
            end
            MOVE: begin
                if (mv.frame_tick) begin
                    if (sub_q + STEP == SUB_END) begin
                        sub_d   = '0;
                        tile_d  = (tile_q == 5'(BOARD_TILES - 1)) ? 5'd0 : tile_q + 5'd1;
                        steps_d = steps_q - 4'd1;
                        if (steps_q == 4'd1) state_d = DONE;
                    end else begin
                        sub_d = sub_q + STEP;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    board_tile_lut u_lut (
        .tile_idx_i (tile_d),
        .col_o      (col),
        .row_o      (row)
    );

`ifdef PLAYER_HOP_EN
    logic [2*SUBW-1:0] prod;
    always_comb begin
        prod = {{SUBW{1'b0}}, sub_d} * {{SUBW{1'b0}}, SUB_END - sub_d};
        lift = (state_d == MOVE) ? 10'(prod >> 5) : 10'd0;
    end
`else
    assign lift = '0;
`endif

    // Position is computed from next-state values so the registered outputs track the tick edge.
    always_comb begin
        base_x = X0 + (10'(col) << SH) + OFS;
        base_y = Y0 + (10'(row) << SH) + OFS;
        sub10  = 10'(sub_d);
        x_d    = base_x;
        y_d    = base_y - lift;
        unique case (tile_dir(tile_d))
            RIGHT: x_d = base_x + sub10;
            DOWN:  y_d = base_y + sub10 - lift;
            LEFT:  x_d = base_x - sub10;
            UP:    y_d = base_y - sub10 - lift;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            steps_q <= '0;
            sub_q   <= '0;
            tile_q  <= '0;
            x_q     <= X0 + OFS;
            y_q     <= Y0 + OFS;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            sub_q   <= sub_d;
            tile_q  <= tile_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign mv.player_x   = x_q;
    assign mv.player_y   = y_q;
    assign mv.tile_idx   = tile_q;
    assign mv.busy       = (state_q != IDLE);
    assign mv.move_ready = (state_q == IDLE);
    assign mv.done       = (state_q == DONE);
endmodule

// File: tb/tb_player_mover.sv
// Directed test of player_mover: reset, single step, wrap, zero-step, ignored request, mid-move reset.
module tb_player_mover;
    logic clk = 1'b0;
    logic reset = 1'b1;
    player_mover_if mv ();

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    always #5 clk = ~clk;

    player_mover dut (
        .clk   (clk),
        .reset (reset),
        .mv    (mv)
    );

    always @(negedge clk) if (mv.done) done_cnt++;

    function automatic int lift_of(input int sub);
`ifdef PLAYER_HOP_EN
        return (sub * (32 - sub)) >> 5;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int steps);
        mv.move_valid = 1'b1;
        mv.move_steps = 4'(steps);
        cyc();
        mv.move_valid = 1'b0;
        mv.move_steps = 4'd0;
    endtask

    task automatic ftick();
        mv.frame_tick = 1'b1;
        cyc();
        mv.frame_tick = 1'b0;
    endtask

    task automatic run_to_done(output int nt);
        nt = 0;
        while (!mv.done && nt < 400) begin
            ftick();
            nt++;
        end
        chk("done_reached", int'(mv.done), 1);
    endtask

    initial begin
        int nt;
        int dc;
        mv.frame_tick = 1'b0;
        mv.move_valid = 1'b0;
        mv.move_steps = 4'd0;

        // Reset and idle
        repeat (3) cyc();
        reset = 1'b0;
        repeat (5) cyc();
        chk("rst_tile", int'(mv.tile_idx), 0);
        chk("rst_x", int'(mv.player_x), 200);
        chk("rst_y", int'(mv.player_y), 120);
        chk("rst_ready", int'(mv.move_ready), 1);
        chk("rst_busy", int'(mv.busy), 0);
        chk("rst_done_cnt", done_cnt, 0);

        // One step, with a tick coincident with acceptance that must not count
        mv.frame_tick = 1'b1;
        send(1);
        mv.frame_tick = 1'b0;
        chk("s1_busy", int'(mv.busy), 1);
        chk("s1_ready", int'(mv.move_ready), 0);
        chk("s1_x_nomove", int'(mv.player_x), 200);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            ftick();
            chk("s1_x", int'(mv.player_x), 200 + 2 * k);
            chk("s1_y", int'(mv.player_y), 120 - lift_of((2 * k) % 32));
            chk("s1_done", int'(mv.done), (k == 16) ? 1 : 0);
        end
        chk("s1_tile", int'(mv.tile_idx), 1);
        cyc();
        chk("s1_done_off", int'(mv.done), 0);
        chk("s1_ready_back", int'(mv.move_ready), 1);
        chk("s1_done_cnt", done_cnt, 1);

        // Advance to tile 26 via tile 16
        send(15);
        run_to_done(nt);
        chk("t16_ticks", nt, 15 * 16);
        chk("t16_tile", int'(mv.tile_idx), 16);
        chk("t16_x", int'(mv.player_x), 360);
        chk("t16_y", int'(mv.player_y), 344);
        cyc();
        send(10);
        run_to_done(nt);
        chk("t26_tile", int'(mv.tile_idx), 26);
        chk("t26_x", int'(mv.player_x), 200);
        chk("t26_y", int'(mv.player_y), 184);
        cyc();

        // Wrap 26 -> 27 -> 0 -> 1
        send(3);
        for (int k = 1; k <= 32; k++) begin
            ftick();
            chk("wrap_y", int'(mv.player_y), 184 - 2 * k - lift_of((2 * k) % 32));
            chk("wrap_x", int'(mv.player_x), 200);
        end
        chk("wrap_tile0", int'(mv.tile_idx), 0);
        for (int k = 1; k <= 16; k++) begin
            ftick();
            chk("wrap_x1", int'(mv.player_x), 200 + 2 * k);
        end
        chk("wrap_tile1", int'(mv.tile_idx), 1);
        chk("wrap_fx", int'(mv.player_x), 232);
        chk("wrap_fy", int'(mv.player_y), 120);
        chk("wrap_done", int'(mv.done), 1);
        cyc();

        // Zero-step request
        dc = done_cnt;
        send(0);
        chk("z_done", int'(mv.done), 1);
        chk("z_busy", int'(mv.busy), 1);
        cyc();
        chk("z_done_off", int'(mv.done), 0);
        chk("z_busy_off", int'(mv.busy), 0);
        chk("z_ready", int'(mv.move_ready), 1);
        chk("z_x", int'(mv.player_x), 232);
        chk("z_y", int'(mv.player_y), 120);
        chk("z_done_cnt", done_cnt, dc + 1);

        // Request pulsed mid-move is ignored
        send(3);
        repeat (5) ftick();
        send(5);
        run_to_done(nt);
        chk("ign_ticks", nt + 5, 48);
        chk("ign_tile", int'(mv.tile_idx), 4);
        chk("ign_x", int'(mv.player_x), 328);
        chk("ign_y", int'(mv.player_y), 120);
        cyc();
        chk("ign_ready", int'(mv.move_ready), 1);

        // Reset during a move
        dc = done_cnt;
        send(4);
        repeat (10) ftick();
        chk("mr_x_pre", int'(mv.player_x), 348);
        #2 reset = 1'b1;
        #1;
        chk("mr_tile", int'(mv.tile_idx), 0);
        chk("mr_x", int'(mv.player_x), 200);
        chk("mr_y", int'(mv.player_y), 120);
        chk("mr_busy", int'(mv.busy), 0);
        cyc();
        reset = 1'b0;
        repeat (3) cyc();
        chk("mr_ready", int'(mv.move_ready), 1);
        chk("mr_no_done", done_cnt, dc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/player_mover.md
# player_mover

Sequential position generator for one board token. It accepts a step count from the game-logic FSM over a valid/ready handshake. It then walks the token tile-by-tile around the board perimeter, advancing a fixed number of pixels per video frame. It drives the `player_x`/`player_y` inputs of the player renderer: the top-left of the 16x16 sprite, in screen pixels.

## Interface
- `BOARD_X0`, 192: screen x of the board's left edge.
- `BOARD_Y0`, 112: screen y of the board's top edge.
- `TILE_PX`, 32: tile pitch in pixels; power of two, ≥16.
- `PIX_PER_FRAME`, 2: pixels advanced per `frame_tick`; must divide `TILE_PX`.
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse per frame (vsync start).
- `move_valid`, in, 1: move request valid.
- `move_steps`, in, 4: tiles to advance, 0–15.
- `move_ready`, out, 1: block can accept a request.
- `player_x`, out, 10: sprite top-left x.
- `player_y`, out, 10: sprite top-left y.
- `tile_idx`, out, 5: current tile, 0–27.
- `busy`, out, 1: a move is in progress.
- `done`, out, 1: one-cycle pulse when a move completes.

## Operation
- Board path: 28 tiles on the perimeter of an 8x8 grid, numbered clockwise.
  - Top row: tiles 0–7, col 0..7, row 0.
  - Right column: tiles 8–13, col 7, row 1..6.
  - Bottom row: tiles 14–21, col 7..0, row 7.
  - Left column: tiles 22–27, col 0, row 6..1.
- Step direction from tile i: RIGHT for i 0–6, DOWN for 7–13, LEFT for 14–20, UP for 21–27. Tile 27 advances to tile 0 (wrap).
- Base position: `x = BOARD_X0 + col*TILE_PX + (TILE_PX-16)/2`; same form for y with `BOARD_Y0`/row. All arithmetic is 10-bit unsigned.
- State machine:
  - IDLE: `move_ready=1`. On `move_valid && move_ready`, latch `move_steps` into `steps_left` and clear the sub-pixel offset `sub` (0..TILE_PX-1). Go to DONE if steps = 0, else MOVE.
  - MOVE: on each `frame_tick`, `sub += PIX_PER_FRAME`. When `sub` reaches `TILE_PX`:
    - `sub` returns to 0 and `tile_idx` advances (mod 28).
    - `steps_left` decrements.
    - If `steps_left` becomes 0, go to DONE.
  - DONE: `done=1` for exactly one cycle, then IDLE.
- Output position = base position of `tile_idx` + `sub` applied along the current direction. Outputs are registered.
- `busy = (state != IDLE)`. `move_ready = (state == IDLE)`.
- `move_valid` in MOVE or DONE is ignored; it is not queued. `move_steps` is sampled only at the handshake.
- Reset mid-move: state IDLE, `tile_idx=0`, `sub=0`, no `done` pulse.
- Reset values: `tile_idx=0`, `player_x=BOARD_X0+8`, `player_y=BOARD_Y0+8` (default params: 200, 120), `busy=0`, `done=0`, `move_ready=1` once reset deasserts.

## Timing
- Handshake completes at the accepting clock edge. `busy` is high the next cycle.
- A `frame_tick` coincident with acceptance is not counted. Motion starts on the first `frame_tick` after acceptance.
- Position outputs update at the clock edge on which `frame_tick` is sampled high. Latency is one cycle from `frame_tick`.
- One tile takes `TILE_PX/PIX_PER_FRAME` frame_ticks (16 at defaults).
- `done` is high the cycle after the final tile update. `move_ready` returns the cycle after `done`.
- A steps = 0 request gives: handshake, then `done` next cycle, then ready next cycle. Position is unchanged.

## Configuration
- `PLAYER_HOP_EN` defined: during MOVE, `player_y = base_y - lift`, with `lift = (sub*(TILE_PX-sub)) >> 5`. This gives an 8-pixel peak at sub = 16 with the default `TILE_PX`. `lift` is 0 at tile boundaries and in IDLE/DONE.
- Undefined: `lift` is tied to 0 and no multiplier is synthesised. Motion is flat.

## Structure
- Shared package `board_pkg` holds:
  - constants `BOARD_TILES=28` and `SPRITE_PX=16`;
  - enum `dir_t` {RIGHT, DOWN, LEFT, UP};
  - enum `mover_state_t` {IDLE, MOVE, DONE};
  - function `tile_dir(idx)`.
- Sub-module `board_tile_lut`: combinational tile index → {col, row}. It is reused by other board renderers.

## Test plan
- Reset, hold idle → `tile_idx=0`, (x, y) = (200, 120), `move_ready=1`, `done` never pulses.
- Request steps = 1, 16 frame_ticks → x steps 202, 204 … 232; `tile_idx=1`; `done` pulses once, one cycle after the 16th tick.
- Start at tile 26, request steps = 3 → path 27, 0, 1 with wrap. Final (x, y) = (232, 120); y decreases by 2 per tick while moving 27→0.
- Request steps = 0 → `done` the cycle after the handshake; position unchanged; `busy` high for exactly 1 cycle.
- `move_valid` with steps = 5 pulsed mid-move → ignored; the original move finishes at its own count.
- Assert `reset` after 10 ticks of a 4-step move → immediate return to tile 0, (200, 120), no `done`.
- With `PLAYER_HOP_EN`: at sub = 16 on a top-row move, `player_y = 112`.
